mul_div_unit: RTL and testbench
===============================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameter: WIDTH, 32, operand and HI/LO width in bits; legal values 8..64, even.
REQ-002 Port: clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 Port: resetn  input  1  reset, asynchronous and active-low.
REQ-004 Port: start_i  input  1  operation request; SHALL be sampled only in IDLE or DONE.
REQ-005 Port: op_i  input  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others are no-ops.
REQ-006 Port: a_i  input  WIDTH  rs operand (dividend, multiplicand, or MTHI/MTLO data).
REQ-007 Port: b_i  input  WIDTH  rt operand (divisor, multiplier).
REQ-008 Port: cancel_i  input  1  pipeline flush; aborts any in-flight operation.
REQ-009 Port: busy_o  output  1  high while in MUL or DIV state; the pipeline stalls on it.
REQ-010 Port: done_o  output  1  one-cycle pulse in the first cycle hi_o/lo_o show a new MULT/DIV result.
REQ-011 Port: hi_o  output  WIDTH  architectural HI register.
REQ-012 Port: lo_o  output  WIDTH  architectural LO register.
REQ-013 Port: dbz_o  output  1  registered flag; set with done_o for a divide by zero, cleared on the next accepted start.

Function
REQ-014 The FSM SHALL have states IDLE, MUL, DIV and DONE; DONE SHALL last exactly one cycle and then go to IDLE unless a new start is accepted.
REQ-015 Operands SHALL be latched on the accepted start edge; later changes to a_i/b_i SHALL have no effect.
REQ-016 MTHI/MTLO accepted at edge T SHALL write hi_o/lo_o at that edge, with no busy_o and no done_o.
REQ-017 MULT/MULTU accepted at edge T: full 2*WIDTH product registered into MUL at T+1; {hi,lo} written and done_o high at T+2.
REQ-018 DIV/DIVU accepted at T: radix-2 restoring divide, one quotient bit per cycle in DIV for WIDTH cycles; {hi,lo} written and done_o high at T+WIDTH+1.
REQ-019 Signed divide SHALL run on magnitudes: quotient negated when a_i and b_i signs differ, remainder takes the sign of a_i.
REQ-020 Signed most-negative / -1 SHALL yield lo = most-negative value and hi = 0, with no flag.
REQ-021 Divide by zero SHALL still take WIDTH+1 cycles, yield lo = all ones and hi = a_i, and set dbz_o.
REQ-022 lo SHALL hold the low WIDTH bits (product or quotient) and hi the high bits (product or remainder).
REQ-023 start_i while busy_o is high SHALL be ignored.
REQ-024 start_i in DONE SHALL be accepted, giving back-to-back operations.
REQ-025 cancel_i in MUL or DIV SHALL return the FSM to IDLE at the next edge, with hi/lo unchanged and no done_o.
REQ-026 cancel_i together with start_i SHALL cancel and not accept the new start, MTHI/MTLO included.
REQ-027 cancel_i on the edge that would write HI/LO SHALL suppress that write.

Reset
REQ-028 resetn low SHALL immediately force IDLE, busy_o=0, done_o=0, dbz_o=0, hi_o=0 and lo_o=0, including mid-operation.
REQ-029 The first start SHALL be accepted on the first rising edge at which resetn is high.

Configuration
REQ-030 Macro MDU_DIV_EN defined: DIV/DIVU SHALL behave per REQ-018..REQ-021.
REQ-031 MDU_DIV_EN undefined: no divider logic; DIV/DIVU SHALL go directly to DONE at T+1 with done_o=1, dbz_o=1 and hi/lo unchanged.

Verification (WIDTH=32, MDU_DIV_EN defined)
REQ-032 MULT a=0xFFFFFFFD (-3), b=5 at T -> done_o at T+2, hi=0xFFFFFFFF, lo=0xFFFFFFF1; MULTU of the same operands -> hi=0x00000004, lo=0xFFFFFFF1.
REQ-033 DIVU a=100, b=7 at T -> busy_o high T+1..T+32, done_o at T+33, lo=14, hi=2, dbz_o=0.
REQ-034 DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-035 DIV a=0x1234, b=0 -> done_o at T+33, lo=0xFFFFFFFF, hi=0x1234, dbz_o=1.
REQ-036 MTHI 0xAA at T, then DIVU 9/3 with cancel_i at T+10 -> IDLE at T+11, no done_o, hi=0xAA; start_i during busy_o is ignored.
REQ-037 resetn low at T+5 of a DIV -> busy_o, hi_o and lo_o are 0 immediately; a MULT accepted after release completes normally at +2.

Source files
------------

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mul_div_unit
// Desc     : HI/LO multiply/divide unit with a two-cycle multiplier and an
//            optional radix-2 restoring divider (define MDU_DIV_EN).
// Revision : 1.0  initial release
// ============================================================================
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cancel_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             dbz_o
);

    localparam logic [2:0] c_OP_MULT  = 3'b000;
    localparam logic [2:0] c_OP_MULTU = 3'b001;
    localparam logic [2:0] c_OP_DIV   = 3'b010;
    localparam logic [2:0] c_OP_DIVU  = 3'b011;
    localparam logic [2:0] c_OP_MTHI  = 3'b100;
    localparam logic [2:0] c_OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_signed;
    logic               r_mul_ph;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2*WIDTH-1:0] r_prod;
    logic [2*WIDTH-1:0] w_prod;
    logic               w_accept;
    logic               w_op_signed;

    assign w_accept    = start_i && !cancel_i && (r_state == S_IDLE || r_state == S_DONE);
    assign w_op_signed = (op_i == c_OP_MULT) || (op_i == c_OP_DIV);

    // Sign-extending both operands to 2*WIDTH makes one multiplier serve MULT and MULTU.
    assign w_prod = {{WIDTH{r_signed & r_a[WIDTH-1]}}, r_a} *
                    {{WIDTH{r_signed & r_b[WIDTH-1]}}, r_b};

`ifdef MDU_DIV_EN
    localparam int                 c_CNT_W    = $clog2(WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH);

    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_dvs;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_dbz;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH-1:0]   w_quo_res;
    logic [WIDTH-1:0]   w_rem_res;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_trial;

    assign w_a_mag   = (w_op_signed && a_i[WIDTH-1]) ? -a_i : a_i;
    assign w_b_mag   = (w_op_signed && b_i[WIDTH-1]) ? -b_i : b_i;
    // r_quo doubles as the dividend shift register: its MSB feeds the partial remainder.
    assign w_shift   = {r_rem, r_quo[WIDTH-1]};
    assign w_trial   = w_shift - {1'b0, r_dvs};
    assign w_quo_res = r_neg_q ? -r_quo : r_quo;
    assign w_rem_res = r_neg_r ? -r_rem : r_rem;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_signed <= 1'b0;
            r_mul_ph <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_prod   <= '0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            dbz_o    <= 1'b0;
            hi_o     <= '0;
            lo_o     <= '0;
`ifdef MDU_DIV_EN
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvs    <= '0;
            r_cnt    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dbz    <= 1'b0;
`endif
        end else begin
            done_o <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_state <= S_IDLE;
                    busy_o  <= 1'b0;
                    if (w_accept) begin
                        dbz_o    <= 1'b0;
                        r_a      <= a_i;
                        r_b      <= b_i;
                        r_signed <= w_op_signed;
                        case (op_i)
                            c_OP_MULT, c_OP_MULTU: begin
                                r_state  <= S_MUL;
                                r_mul_ph <= 1'b0;
                                busy_o   <= 1'b1;
                            end
                            c_OP_DIV, c_OP_DIVU: begin
                                r_state <= S_DIV;
                                busy_o  <= 1'b1;
`ifdef MDU_DIV_EN
                                r_rem   <= '0;
                                r_quo   <= w_a_mag;
                                r_dvs   <= w_b_mag;
                                r_cnt   <= '0;
                                r_neg_q <= w_op_signed && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                                r_neg_r <= w_op_signed && a_i[WIDTH-1];
                                r_dbz   <= (b_i == '0);
`endif
                            end
                            c_OP_MTHI: hi_o <= a_i;
                            c_OP_MTLO: lo_o <= a_i;
                            default: ;
                        endcase
                    end
                end

                S_MUL: begin
                    if (cancel_i) begin
                        r_state <= S_IDLE;
                        busy_o  <= 1'b0;
                    end else if (!r_mul_ph) begin
                        r_prod   <= w_prod;
                        r_mul_ph <= 1'b1;
                    end else begin
                        {hi_o, lo_o} <= r_prod;
                        done_o       <= 1'b1;
                        busy_o       <= 1'b0;
                        r_state      <= S_DONE;
                    end
                end

                S_DIV: begin
                    if (cancel_i) begin
                        r_state <= S_IDLE;
                        busy_o  <= 1'b0;
                    end else begin
`ifdef MDU_DIV_EN
                        if (r_cnt != c_CNT_LAST) begin
                            r_cnt <= r_cnt + 1'b1;
                            if (!w_trial[WIDTH]) begin
                                r_rem <= w_trial[WIDTH-1:0];
                                r_quo <= {r_quo[WIDTH-2:0], 1'b1};
                            end else begin
                                r_rem <= w_shift[WIDTH-1:0];
                                r_quo <= {r_quo[WIDTH-2:0], 1'b0};
                            end
                        end else begin
                            hi_o    <= r_dbz ? r_a : w_rem_res;
                            lo_o    <= r_dbz ? '1  : w_quo_res;
                            dbz_o   <= r_dbz;
                            done_o  <= 1'b1;
                            busy_o  <= 1'b0;
                            r_state <= S_DONE;
                        end
`else
                        // Without a divider DIV/DIVU only report completion with the dbz flag.
                        dbz_o   <= 1'b1;
                        done_o  <= 1'b1;
                        busy_o  <= 1'b0;
                        r_state <= S_DONE;
`endif
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_div_unit
// Desc     : Self-checking bench for mul_div_unit against an arithmetic model.
// Revision : 1.0  initial release
// ============================================================================
module tb_mul_div_unit;
    localparam int W = 32;
    localparam logic [2:0] c_MULT  = 3'd0;
    localparam logic [2:0] c_MULTU = 3'd1;
    localparam logic [2:0] c_DIV   = 3'd2;
    localparam logic [2:0] c_DIVU  = 3'd3;
    localparam logic [2:0] c_MTHI  = 3'd4;
    localparam logic [2:0] c_MTLO  = 3'd5;
`ifdef MDU_DIV_EN
    localparam logic [2:0] c_LONG_OP  = c_DIVU;
    localparam int         c_CANCEL_AT = 10;
    localparam int         c_RST_AT    = 5;
`else
    localparam logic [2:0] c_LONG_OP  = c_MULT;
    localparam int         c_CANCEL_AT = 1;
    localparam int         c_RST_AT    = 1;
`endif

    logic         clk = 1'b0;
    logic         resetn = 1'b1;
    logic         start_i = 1'b0;
    logic [2:0]   op_i = '0;
    logic [W-1:0] a_i = '0;
    logic [W-1:0] b_i = '0;
    logic         cancel_i = 1'b0;
    logic         busy_o;
    logic         done_o;
    logic [W-1:0] hi_o;
    logic [W-1:0] lo_o;
    logic         dbz_o;

    mul_div_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .start_i  (start_i),
        .op_i     (op_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .cancel_i (cancel_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .hi_o     (hi_o),
        .lo_o     (lo_o),
        .dbz_o    (dbz_o)
    );

    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_pass   = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    logic         m_dbz = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Architectural result of one operation; lat = edges from accept to done (0 = no done).
    function automatic void model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output int lat, output logic [W-1:0] hi, output logic [W-1:0] lo,
                                  output logic dbz);
        longint       sa, sb, q, r;
        logic [63:0]  p;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        hi  = m_hi;
        lo  = m_lo;
        dbz = 1'b0;
        lat = 0;
        case (op)
            c_MULT:  begin p = 64'(sa * sb); {hi, lo} = p; lat = 2; end
            c_MULTU: begin p = {32'd0, a} * {32'd0, b}; {hi, lo} = p; lat = 2; end
            c_DIV, c_DIVU: begin
`ifdef MDU_DIV_EN
                lat = W + 1;
                if (b == 0) begin
                    lo = '1; hi = a; dbz = 1'b1;
                end else if (op == c_DIV) begin
                    q = sa / sb; r = sa % sb;
                    lo = q[31:0]; hi = r[31:0];
                end else begin
                    lo = a / b; hi = a % b;
                end
`else
                lat = 1; dbz = 1'b1;
`endif
            end
            c_MTHI: hi = a;
            c_MTLO: lo = a;
            default: ;
        endcase
    endfunction

    // Call at posedge+1; the start is accepted at the next edge.
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input string tag);
        int           lat, k;
        logic [W-1:0] ehi, elo;
        logic         edbz;
        bit           seen, busy_ok;
        model(op, a, b, lat, ehi, elo, edbz);
        start_i = 1'b1; op_i = op; a_i = a; b_i = b;
        @(posedge clk); #1;
        start_i = 1'b0; op_i = 3'($urandom); a_i = $urandom; b_i = $urandom;
        check({tag, " dbz_clr"}, dbz_o, 0);
        if (lat == 0) begin
            check({tag, " busy"}, busy_o, 0);
            check({tag, " done"}, done_o, 0);
            check({tag, " hi"}, hi_o, ehi);
            check({tag, " lo"}, lo_o, elo);
        end else begin
            seen = 0; busy_ok = 1;
            for (k = 1; k <= 2 * W + 8; k++) begin
                @(posedge clk); #1;
                if (done_o) begin seen = 1; break; end
                if (!busy_o) busy_ok = 0;
            end
            check({tag, " lat"}, seen ? 64'(k) : 64'hFFFF, 64'(lat));
            if (lat > 1) check({tag, " busy_run"}, busy_ok, 1);
            if (seen) begin
                check({tag, " hi"}, hi_o, ehi);
                check({tag, " lo"}, lo_o, elo);
                check({tag, " dbz"}, dbz_o, edbz);
                check({tag, " busy_done"}, busy_o, 0);
            end
        end
        m_hi = ehi; m_lo = elo; m_dbz = edbz;
    endtask

    task automatic idle_check(input string tag);
        @(posedge clk); #1;
        check({tag, " done_1cyc"}, done_o, 0);
        check({tag, " idle_busy"}, busy_o, 0);
    endtask

    initial begin
        int           lat;
        logic [W-1:0] ehi, elo, ra, rb;
        logic         edbz;
        bit           no_done;
        int           sel;

        #2 resetn = 1'b0;
        #1;
        check("rst busy", busy_o, 0);
        check("rst done", done_o, 0);
        check("rst hi", hi_o, 0);
        check("rst lo", lo_o, 0);
        check("rst dbz", dbz_o, 0);
        repeat (2) @(posedge clk);
        #2 resetn = 1'b1;

        run_op(c_MULT,  32'hFFFF_FFFD, 32'd5, "mult_neg");
        run_op(c_MULTU, 32'hFFFF_FFFD, 32'd5, "multu");
        run_op(c_DIVU,  32'd100, 32'd7, "divu_100_7");
        run_op(c_DIV,   32'hFFFF_FFF9, 32'd2, "div_m7_2");
        run_op(c_DIV,   32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        run_op(c_DIV,   32'h0000_1234, 32'd0, "div_by0");
        run_op(c_MULTU, 32'd3, 32'd4, "after_dbz");
        idle_check("post_b2b");
        run_op(c_MTLO,  32'h1357_9BDF, 32'd0, "mtlo");
        run_op(3'd7,    32'hDEAD_BEEF, 32'd1, "nop7");

        // start_i held during a multiply must be ignored
        model(c_MULT, 32'd7, 32'hFFFF_FFFA, lat, ehi, elo, edbz);
        start_i = 1'b1; op_i = c_MULT; a_i = 32'd7; b_i = 32'hFFFF_FFFA;
        @(posedge clk); #1;
        op_i = c_MTLO; a_i = 32'h55;
        @(posedge clk); #1;
        check("ign busy", busy_o, 1);
        check("ign lo_hold", lo_o, m_lo);
        @(posedge clk); #1;
        start_i = 1'b0;
        check("ign done", done_o, 1);
        check("ign hi", hi_o, ehi);
        check("ign lo", lo_o, elo);
        m_hi = ehi; m_lo = elo; m_dbz = 1'b0;
        idle_check("ign");

        // flush of a long operation
        run_op(c_MTHI, 32'hAA, 32'd0, "mthi_aa");
        start_i = 1'b1; op_i = c_LONG_OP; a_i = 32'd9; b_i = 32'd3;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (c_CANCEL_AT - 1) @(posedge clk);
        #1 cancel_i = 1'b1;
        @(posedge clk); #1;
        cancel_i = 1'b0;
        check("cancel busy", busy_o, 0);
        check("cancel done", done_o, 0);
        check("cancel hi", hi_o, 32'hAA);
        check("cancel lo", lo_o, m_lo);
        no_done = 1;
        repeat (W + 4) begin
            @(posedge clk); #1;
            if (done_o) no_done = 0;
        end
        check("cancel no_done", no_done, 1);

        // cancel on the write edge
        start_i = 1'b1; op_i = c_MULTU; a_i = 32'hFFFF; b_i = 32'hFFFF;
        @(posedge clk); #1;
        start_i = 1'b0;
        @(posedge clk); #1;
        cancel_i = 1'b1;
        @(posedge clk); #1;
        cancel_i = 1'b0;
        check("cwr done", done_o, 0);
        check("cwr hi", hi_o, m_hi);
        check("cwr lo", lo_o, m_lo);
        check("cwr busy", busy_o, 0);

        // cancel together with start blocks MTHI
        start_i = 1'b1; cancel_i = 1'b1; op_i = c_MTHI; a_i = 32'h77;
        @(posedge clk); #1;
        start_i = 1'b0; cancel_i = 1'b0;
        check("cst hi", hi_o, m_hi);
        check("cst busy", busy_o, 0);

        for (int i = 0; i < 60; i++) begin
            sel = int'($urandom_range(0, 7));
            ra = $urandom;
            rb = (sel == 0) ? 32'd0 : (sel == 1) ? 32'($urandom_range(1, 15)) : $urandom;
            if (sel == 2) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            run_op(3'($urandom_range(0, 7)), ra, rb, $sformatf("rnd%0d", i));
            if ($urandom_range(0, 1) == 1) idle_check($sformatf("rnd%0d", i));
        end

        // asynchronous reset in the middle of a long operation
        start_i = 1'b1; op_i = c_LONG_OP; a_i = 32'h1000; b_i = 32'd3;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (c_RST_AT) @(posedge clk);
        #3 resetn = 1'b0;
        #1;
        check("mrst busy", busy_o, 0);
        check("mrst done", done_o, 0);
        check("mrst hi", hi_o, 0);
        check("mrst lo", lo_o, 0);
        check("mrst dbz", dbz_o, 0);
        m_hi = '0; m_lo = '0; m_dbz = 1'b0;
        @(posedge clk);
        #2 resetn = 1'b1;
        run_op(c_MULT, 32'h0001_0003, 32'hFFFF_0002, "post_rst");
        idle_check("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks so far", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
